// File: rtl/nibble_serial_adder.sv
// -----------------------------------------------------------------------------
// nibble_serial_adder
//
// Multi-cycle WIDTH-bit adder. A single 4-bit carry-lookahead slice is reused
// once per cycle, least-significant nibble first. A registered carry links
// consecutive nibbles. The result is A + B + cin modulo 2^WIDTH, plus the carry
// out of the MSB and a signed-overflow flag. Only one operation is in flight at
// a time. Minimum initiation interval is N+2 cycles, where N = WIDTH/4.
//
// Parameters
//   WIDTH      operand/result width in bits; must be a multiple of 4 and >= 8
//
// Ports
//   clk        in   rising-edge clock
//   reset      in   synchronous, active-high reset
//   in_valid   in   a, b, cin valid
//   in_ready   out  block can accept operands (high only in IDLE)
//   a          in   operand A [WIDTH-1:0]
//   b          in   operand B [WIDTH-1:0]
//   cin        in   carry into bit 0
//   out_valid  out  sum, cout, ovf valid (high only in DONE)
//   out_ready  in   consumer takes the result
//   sum        out  A + B + cin, modulo 2^WIDTH
//   cout       out  carry out of bit WIDTH-1
//   ovf        out  signed (two's-complement) overflow flag
//
// Build option
//   NIBBLE_ADDER_OVF_EN
//     Defined:   ovf is computed and registered alongside cout.
//     Undefined: ovf is tied to 0 and the carry-into-MSB tracking is dropped.
//     The ovf port exists in both builds.
// -----------------------------------------------------------------------------
module nibble_serial_adder #(
    parameter int WIDTH = 16
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             cin,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] sum,
    output logic             cout,
    output logic             ovf
);

    localparam int N  = WIDTH / 4;
    localparam int KW = (N > 1) ? $clog2(N) : 1;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_e;

    // -------------------------------------------------------------------------
    // State and datapath registers
    // -------------------------------------------------------------------------
    state_e            state_q;
    logic [WIDTH-1:0]  a_q;
    logic [WIDTH-1:0]  b_q;
    logic [WIDTH-1:0]  sum_q;
    logic              carry_q;
    logic              cout_q;
    logic [KW-1:0]     k_q;
    logic              last_nibble;

`ifdef NIBBLE_ADDER_OVF_EN
    logic              ovf_q;
`endif

    // -------------------------------------------------------------------------
    // 4-bit carry-lookahead slice on nibble k of the latched operands
    // -------------------------------------------------------------------------
    logic [3:0] nib_a;
    logic [3:0] nib_b;
    logic [3:0] slice_g;
    logic [3:0] slice_p;
    logic [4:0] slice_c;
    logic [3:0] slice_s;

    // The nibble base index is k*4, formed by appending two zero bits.
    always_comb begin
        // NOTE: every variable written here gets a value on every path first, so
        // no latch can be inferred even if the body grows conditional branches.
        nib_a   = a_q[{k_q, 2'b00} +: 4];
        nib_b   = b_q[{k_q, 2'b00} +: 4];
        slice_g = nib_a & nib_b;
        slice_p = nib_a | nib_b;

        // Carries are expanded to two-level lookahead form rather than rippled,
        // so each c(i+1) depends only on g, p and the incoming carry.
        slice_c[0] = carry_q;
        slice_c[1] = slice_g[0]
                   | (slice_p[0] & carry_q);
        slice_c[2] = slice_g[1]
                   | (slice_p[1] & slice_g[0])
                   | (slice_p[1] & slice_p[0] & carry_q);
        slice_c[3] = slice_g[2]
                   | (slice_p[2] & slice_g[1])
                   | (slice_p[2] & slice_p[1] & slice_g[0])
                   | (slice_p[2] & slice_p[1] & slice_p[0] & carry_q);
        slice_c[4] = slice_g[3]
                   | (slice_p[3] & slice_g[2])
                   | (slice_p[3] & slice_p[2] & slice_g[1])
                   | (slice_p[3] & slice_p[2] & slice_p[1] & slice_g[0])
                   | (slice_p[3] & slice_p[2] & slice_p[1] & slice_p[0] & carry_q);

        slice_s = nib_a ^ nib_b ^ slice_c[3:0];
    end

    assign last_nibble = (k_q == KW'(N - 1));

    // -------------------------------------------------------------------------
    // Control FSM and result registers
    // -------------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (reset) begin
            // NOTE: the datapath registers are reset along with the FSM because
            // sum/cout/ovf are visible outputs with a defined post-reset value;
            // an in-flight operation is simply abandoned.
            state_q <= IDLE;
            a_q     <= '0;
            b_q     <= '0;
            sum_q   <= '0;
            carry_q <= 1'b0;
            cout_q  <= 1'b0;
            k_q     <= '0;
`ifdef NIBBLE_ADDER_OVF_EN
            ovf_q   <= 1'b0;
`endif
        end else begin
            // NOTE: non-blocking assignments throughout, so every register here
            // samples the pre-edge values of the others regardless of order.
            case (state_q)
                IDLE: begin
                    // in_ready is high in IDLE, so in_valid alone is a handshake.
                    if (in_valid) begin
                        a_q     <= a;
                        b_q     <= b;
                        carry_q <= cin;
                        k_q     <= '0;
                        state_q <= RUN;
                    end
                end

                RUN: begin
                    sum_q[{k_q, 2'b00} +: 4] <= slice_s;
                    carry_q                  <= slice_c[4];
                    if (last_nibble) begin
                        // Final nibble: slice_c[4] leaves bit WIDTH-1 and
                        // slice_c[3] enters it.
                        cout_q  <= slice_c[4];
`ifdef NIBBLE_ADDER_OVF_EN
                        ovf_q   <= slice_c[3] ^ slice_c[4];
`endif
                        k_q     <= '0;
                        state_q <= DONE;
                    end else begin
                        k_q     <= k_q + 1'b1;
                    end
                end

                DONE: begin
                    // Results stay frozen until the consumer takes them.
                    if (out_ready) begin
                        state_q <= IDLE;
                    end
                end

                default: begin
                    state_q <= IDLE;
                end
            endcase
        end
    end

    // -------------------------------------------------------------------------
    // Outputs: handshake flags decode the registered state only, so neither
    // depends combinationally on in_valid or out_ready.
    // -------------------------------------------------------------------------
    assign in_ready  = (state_q == IDLE);
    assign out_valid = (state_q == DONE);
    assign sum       = sum_q;
    assign cout      = cout_q;

`ifdef NIBBLE_ADDER_OVF_EN
    assign ovf       = ovf_q;
`else
    assign ovf       = 1'b0;
`endif

endmodule

// File: tb/tb_nibble_serial_adder.sv
// -----------------------------------------------------------------------------
// Testbench for nibble_serial_adder (WIDTH = 16).
// Expected results come from a plain-arithmetic reference model and are pushed
// into a scoreboard queue when operands are issued; a monitor process pops and
// compares whenever the DUT completes an output handshake.
// -----------------------------------------------------------------------------
module tb_nibble_serial_adder;

    localparam int WIDTH = 16;
    localparam int N     = WIDTH / 4;

    typedef struct {
        logic [WIDTH-1:0] sum;
        logic             cout;
        logic             ovf;
    } exp_t;

    logic             clk;
    logic             reset;
    logic             in_valid;
    logic             in_ready;
    logic [WIDTH-1:0] a;
    logic [WIDTH-1:0] b;
    logic             cin;
    logic             out_valid;
    logic             out_ready;
    logic [WIDTH-1:0] sum;
    logic             cout;
    logic             ovf;

    int   total = 0;
    int   bad   = 0;
    exp_t exp_q[$];

    nibble_serial_adder #(.WIDTH(WIDTH)) dut (
        .clk       (clk),
        .reset     (reset),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .a         (a),
        .b         (b),
        .cin       (cin),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .sum       (sum),
        .cout      (cout),
        .ovf       (ovf)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // -------------------------------------------------------------------------
    // Reference model: full-precision integer addition
    // -------------------------------------------------------------------------
    function automatic exp_t model(input logic [WIDTH-1:0] x,
                                   input logic [WIDTH-1:0] y,
                                   input logic             c);
        logic [WIDTH:0] full;
        exp_t           e;
        full   = {1'b0, x} + {1'b0, y} + {{WIDTH{1'b0}}, c};
        e.sum  = full[WIDTH-1:0];
        e.cout = full[WIDTH];
`ifdef NIBBLE_ADDER_OVF_EN
        // Signed overflow: same-sign operands giving a result of the other sign.
        e.ovf  = (x[WIDTH-1] == y[WIDTH-1]) && (e.sum[WIDTH-1] != x[WIDTH-1]);
`else
        e.ovf  = 1'b0;
`endif
        return e;
    endfunction

    task automatic check(input string name, input logic [31:0] act,
                         input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // -------------------------------------------------------------------------
    // Monitor: a result is consumed when out_valid & out_ready at an edge
    // -------------------------------------------------------------------------
    always @(negedge clk) begin
        exp_t e;
        if (!reset && out_valid && out_ready) begin
            if (exp_q.size() == 0) begin
                check("unexpected_result", 32'(out_valid), 32'(0));
            end else begin
                e = exp_q.pop_front();
                check("sum",  32'(sum),  32'(e.sum));
                check("cout", 32'(cout), 32'(e.cout));
                check("ovf",  32'(ovf),  32'(e.ovf));
            end
        end
    end

    // -------------------------------------------------------------------------
    // Stimulus helpers
    // -------------------------------------------------------------------------
    // Waits (bounded) for in_ready, presents operands for the accepting edge and
    // returns 1 time unit after that edge.
    task automatic issue(input logic [WIDTH-1:0] ia, input logic [WIDTH-1:0] ib,
                         input logic ic, input bit push);
        int n;
        n = 0;
        @(negedge clk);
        while (!in_ready && n < 20) begin
            @(negedge clk);
            n++;
        end
        if (!in_ready) check("issue_timeout", 32'(in_ready), 32'(1));
        a        = ia;
        b        = ib;
        cin      = ic;
        in_valid = 1'b1;
        if (push) exp_q.push_back(model(ia, ib, ic));
        @(posedge clk);
        #1 in_valid = 1'b0;
    endtask

    // Called just after the accepting edge: counts edges until out_valid shows,
    // checking in_ready stays low while the operation runs.
    task automatic wait_valid();
        int edges;
        bit seen;
        edges = 0;
        seen  = 1'b0;
        while (!seen && edges < 20) begin
            @(posedge clk);
            edges++;
            @(negedge clk);
            if (out_valid) seen = 1'b1;
            else check("in_ready_busy", 32'(in_ready), 32'(0));
        end
        check("latency", 32'(edges), 32'(N));
    endtask

    // -------------------------------------------------------------------------
    // Main sequence
    // -------------------------------------------------------------------------
    initial begin
        exp_t             bp;
        logic [WIDTH-1:0] ra;
        logic [WIDTH-1:0] rb;
        int               stall;

        reset     = 1'b1;
        in_valid  = 1'b0;
        a         = '0;
        b         = '0;
        cin       = 1'b0;
        out_ready = 1'b1;
        repeat (2) @(posedge clk);
        #1 reset = 1'b0;

        // Reset state
        @(negedge clk);
        check("rst_in_ready",  32'(in_ready),  32'(1));
        check("rst_out_valid", 32'(out_valid), 32'(0));
        check("rst_sum",       32'(sum),       32'(0));
        check("rst_cout",      32'(cout),      32'(0));
        check("rst_ovf",       32'(ovf),       32'(0));

        // Directed operand patterns
        issue(16'h1234, 16'h4321, 1'b0, 1'b1);
        wait_valid();
        issue(16'hFFFF, 16'h0001, 1'b0, 1'b1);
        wait_valid();
        issue(16'h7FFF, 16'h0000, 1'b1, 1'b1);
        wait_valid();
        issue(16'h8000, 16'h8000, 1'b0, 1'b1);
        wait_valid();

        // Back-pressure: result held for 5 cycles with out_ready low
        bp = model(16'hBEEF, 16'h1234, 1'b1);
        issue(16'hBEEF, 16'h1234, 1'b1, 1'b1);
        out_ready = 1'b0;
        wait_valid();
        repeat (5) begin
            @(negedge clk);
            check("bp_out_valid", 32'(out_valid), 32'(1));
            check("bp_in_ready",  32'(in_ready),  32'(0));
            check("bp_sum",       32'(sum),       32'(bp.sum));
            check("bp_cout",      32'(cout),      32'(bp.cout));
        end
        @(posedge clk);
        #1 out_ready = 1'b1;
        @(posedge clk);
        @(negedge clk);
        check("bp_release_in_ready",  32'(in_ready),  32'(1));
        check("bp_release_out_valid", 32'(out_valid), 32'(0));

        // in_valid held high with new operands while busy is ignored
        a        = 16'h0F0F;
        b        = 16'h00F1;
        cin      = 1'b0;
        in_valid = 1'b1;
        exp_q.push_back(model(16'h0F0F, 16'h00F1, 1'b0));
        @(posedge clk);
        #1;
        a   = 16'h9999;
        b   = 16'h6667;
        cin = 1'b1;
        wait_valid();
        // Handshake on the next edge, then the held operands are taken in IDLE.
        exp_q.push_back(model(16'h9999, 16'h6667, 1'b1));
        @(posedge clk);
        @(negedge clk);
        check("ignore_back_to_idle", 32'(in_ready), 32'(1));
        @(posedge clk);
        #1 in_valid = 1'b0;
        wait_valid();

        // Reset during RUN at step k=2: operation discarded
        issue(16'hAAAA, 16'h5555, 1'b0, 1'b0);
        @(posedge clk);
        @(posedge clk);
        #1 reset = 1'b1;
        @(posedge clk);
        #1 reset = 1'b0;
        @(negedge clk);
        check("midrst_in_ready",  32'(in_ready),  32'(1));
        check("midrst_out_valid", 32'(out_valid), 32'(0));
        check("midrst_sum",       32'(sum),       32'(0));
        check("midrst_cout",      32'(cout),      32'(0));
        repeat (N + 4) begin
            @(negedge clk);
            check("midrst_no_result", 32'(out_valid), 32'(0));
        end

        // Randomized operands with random consumer stalls
        for (int i = 0; i < 40; i++) begin
            ra = 16'($urandom);
            rb = 16'($urandom);
            case ($urandom_range(0, 7))
                0: ra = 16'h7FFF;
                1: rb = 16'hFFFF;
                2: ra = 16'h8000;
                default: ;
            endcase
            stall = $urandom_range(0, 3);
            issue(ra, rb, 1'($urandom), 1'b1);
            if (stall > 0) out_ready = 1'b0;
            wait_valid();
            if (stall > 0) begin
                repeat (stall) @(posedge clk);
                #1 out_ready = 1'b1;
            end
        end

        repeat (4) @(negedge clk);
        check("scoreboard_empty", 32'(exp_q.size()), 32'(0));

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    // Global time bound so the run always terminates.
    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not complete in time");
        $fatal(1);
    end

endmodule
